// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator stage.
package mac_pkg;

  localparam int unsigned MAC_W     = 64;
  localparam int unsigned MAC_CNT_W = 16;

  localparam logic [MAC_W-1:0] SAT_MAX = {1'b0, {(MAC_W-1){1'b1}}};
  localparam logic [MAC_W-1:0] SAT_MIN = {1'b1, {(MAC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM,
    HOLD
  } mac_state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in and sum-out handshake bundle of the MAC accumulator.
interface mac_accumulator_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_product;
  logic             in_last;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_sat;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_product, in_last, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_product, in_last, clear, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_count
  );

endinterface

// File: rtl/sat_add.sv
// Combinational signed saturating adder.
module sat_add
  import mac_pkg::*;
#(
  parameter int unsigned W = MAC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         ovf
);

  logic [W:0] wide;

  assign wide = {a[W-1], a} + {b[W-1], b};
  // Bits W and W-1 disagree exactly when like-signed operands produce an opposite-signed result.
  assign ovf  = wide[W] ^ wide[W-1];

  always_comb begin
    s = wide[W-1:0];
    if (ovf) begin
      s = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Registers multiplier products and sums them into a saturating accumulator,
// presenting each completed sum through a valid/ready handshake.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned W     = MAC_W,
  parameter int unsigned CNT_W = MAC_CNT_W
) (
  input logic              clk,
  input logic              reset,
  mac_accumulator_if.slave bus
);

  mac_state_t       state_q, state_d;
  logic             p_valid_q, p_valid_d;
  logic             p_last_q, p_last_d;
  logic [W-1:0]     p_reg_q, p_reg_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [W-1:0]     base;
  logic [W-1:0]     sum;
  logic             sum_ovf;
  logic [CNT_W-1:0] count_inc;

  // Handshake outputs depend on registered state only.
  assign bus.in_ready  = (state_q == ACCUM) && !(p_valid_q && p_last_q);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_count = count_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign base      = bus.clear ? '0 : acc_q;
  assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  sat_add #(
    .W (W)
  ) u_sat_add (
    .a   (base),
    .b   (p_reg_q),
    .s   (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sat_d     = sat_q;
    p_valid_d = accept;
    p_last_d  = accept ? bus.in_last : p_last_q;
    p_reg_d   = accept ? bus.in_product : p_reg_q;

    unique case (state_q)
      ACCUM: begin
        if (p_valid_q) begin
          acc_d   = sum;
          // A clear coinciding with a beat restarts the sum from that beat.
          count_d = bus.clear ? CNT_W'(1) : count_inc;
          sat_d   = (bus.clear ? 1'b0 : sat_q) | sum_ovf;
          if (p_last_q) begin
            state_d = HOLD;
          end
        end else if (bus.clear) begin
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_reg_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      p_reg_q   <= p_reg_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a cycle-level reference model.
module tb_mac_accumulator;
  import mac_pkg::*;

  localparam logic signed [64:0] MAXW = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MINW = 65'sh1_8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_accumulator_if #(.W(64), .CNT_W(16)) bus ();

  mac_accumulator #(
    .W     (64),
    .CNT_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state.
  bit                 m_pv = 0;
  bit                 m_pl = 0;
  logic signed [63:0] m_p = '0;
  logic signed [63:0] m_acc = '0;
  int                 m_cnt = 0;
  bit                 m_sat = 0;
  bit                 m_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit                 take;
    bit                 ov;
    logic signed [63:0] base;
    logic signed [64:0] wide;
    take = bus.in_valid && !m_hold && !(m_pv && m_pl);
    if (reset) begin
      m_pv = 0; m_pl = 0; m_acc = '0; m_cnt = 0; m_sat = 0; m_hold = 0;
    end else begin
      if (!m_hold) begin
        if (m_pv) begin
          base = bus.clear ? 64'sd0 : m_acc;
          wide = base + m_p;
          ov   = 0;
          if (wide > MAXW) begin
            m_acc = MAXW[63:0]; ov = 1;
          end else if (wide < MINW) begin
            m_acc = MINW[63:0]; ov = 1;
          end else begin
            m_acc = wide[63:0];
          end
          m_cnt = bus.clear ? 1 : ((m_cnt + 1 > 65535) ? 65535 : m_cnt + 1);
          m_sat = (bus.clear ? 1'b0 : m_sat) | ov;
          if (m_pl) m_hold = 1;
        end else if (bus.clear) begin
          m_acc = '0; m_cnt = 0; m_sat = 0;
        end
      end else if (bus.out_ready) begin
        m_acc = '0; m_cnt = 0; m_sat = 0; m_hold = 0;
      end
      m_pv = take;
      if (take) begin
        m_p  = bus.in_product;
        m_pl = bus.in_last;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("in_ready", 64'(bus.in_ready), 64'(!m_hold && !(m_pv && m_pl)));
    chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
    if (m_hold) begin
      chk("out_sum", bus.out_sum, m_acc);
      chk("out_sat", 64'(bus.out_sat), 64'(m_sat));
      chk("out_count", 64'(bus.out_count), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat and returns just after the edge that accepts it.
  task automatic feed(input logic [63:0] v, input bit last);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = v;
    bus.in_last    = last;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: in_ready stuck 0 for value %h", v);
    end
    tick();
  endtask

  task automatic expect_out(input string name, input logic [63:0] s, input int c, input bit st);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_sum"}, bus.out_sum, s);
    chk({name, "_count"}, 64'(bus.out_count), 64'(c));
    chk({name, "_sat"}, 64'(bus.out_sat), 64'(st));
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.clear      = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);

    // Basic sum with latency check.
    feed(64'd100, 0);
    feed(64'd10000, 0);
    feed(-64'sd25000, 0);
    feed(64'd525, 1);
    bus.in_valid = 1'b0;
    chk("basic_lat_edge1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("basic_lat_edge2", 64'(bus.out_valid), 64'd1);
    chk("basic_sum", bus.out_sum, -64'sd14375);
    chk("basic_count", 64'(bus.out_count), 64'd4);
    chk("basic_sat", 64'(bus.out_sat), 64'd0);
    tick();
    chk("basic_one_cycle", 64'(bus.out_valid), 64'd0);

    // Positive saturation, then a clean sum.
    feed(64'h7FFF_FFFF_FFFF_FFF0, 0);
    feed(64'h20, 1);
    bus.in_valid = 1'b0;
    expect_out("possat", SAT_MAX, 2, 1);
    tick();
    feed(64'd5, 1);
    bus.in_valid = 1'b0;
    expect_out("after_sat", 64'd5, 1, 0);
    tick();

    // Negative saturation and recovery.
    feed(64'h8000_0000_0000_0001, 0);
    feed(-64'sd2, 0);
    feed(64'd1000, 1);
    bus.in_valid = 1'b0;
    expect_out("negsat", 64'h8000_0000_0000_03E8, 3, 1);
    tick();

    // Backpressure on the output while the next beat waits.
    bus.out_ready = 1'b0;
    feed(64'd7, 1);
    bus.in_product = 64'd9;
    bus.in_last    = 1'b1;
    expect_out("bp_hold", 64'd7, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
      chk("bp_sum_stable", bus.out_sum, 64'd7);
      chk("bp_in_blocked", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("bp_in_blocked_hs", 64'(bus.in_ready), 64'd0);
    feed(64'd9, 1);
    bus.in_valid = 1'b0;
    expect_out("bp_next", 64'd9, 1, 0);
    tick();

    // Clear colliding with a beat in stage 2.
    feed(64'd50, 0);
    feed(64'd60, 0);
    bus.clear = 1'b1;
    feed(64'd3, 1);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    expect_out("clear_coll", 64'd63, 2, 0);
    tick();

    // Clear alone mid-sum.
    feed(64'd10, 0);
    feed(64'd20, 0);
    bus.in_valid = 1'b0;
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    feed(64'd4, 1);
    bus.in_valid = 1'b0;
    expect_out("clear_alone", 64'd4, 1, 0);
    tick();

    // Reset during HOLD and during an active sum.
    bus.out_ready = 1'b0;
    feed(64'd11, 1);
    bus.in_valid = 1'b0;
    expect_out("pre_reset", 64'd11, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_hold_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_hold_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    feed(64'd12, 0);
    feed(64'd13, 0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_sum_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum_ready", 64'(bus.in_ready), 64'd1);
    feed(64'd8, 1);
    bus.in_valid = 1'b0;
    expect_out("post_reset", 64'd8, 1, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential stage directly downstream of the 32x32 signed radix-4 Booth multiplier. It registers each 64-bit product, adds it into a signed saturating 64-bit accumulator, and counts the terms. On a last-flagged beat it presents the final sum to the consumer through a valid/ready handshake. The input register also breaks the long combinational path of the multiplier and Kogge-Stone adder chain before the accumulate adder.

## Interface
- `W`, 64: product and accumulator width; product is two's complement.
- `CNT_W`, 16: term-counter width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  product beat offered.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_product`  in  W  signed product from the multiplier `P` output.
- `in_last`  in  1  beat is the final term of the current sum.
- `clear`  in  1  discard the running sum. Sampled only in state ACCUM.
- `out_valid`  out  1  final sum available.
- `out_ready`  in  1  consumer takes the sum.
- `out_sum`  out  W  final saturated sum.
- `out_sat`  out  1  sticky flag: at least one add in this sum saturated.
- `out_count`  out  CNT_W  number of terms in this sum; saturates at all-ones.

## Operation
- **States:** ACCUM, HOLD.
- **Stage 1, input register:**
  - A beat is accepted when `in_valid && in_ready`.
  - An accepted beat loads `p_reg`, sets `p_last` from `in_last`, and sets `p_valid`=1. Otherwise `p_valid` is set to 0.
  - `in_ready = (state==ACCUM) && !(p_valid && p_last)`.
- **Stage 2, accumulate (ACCUM):**
  - When `p_valid` is 1: `acc <= sat_add(base, p_reg)` and `count <= min(count+1, max)`. `sat` is ORed with the adder's saturation flag.
  - `base` = `acc`, or 0 if `clear` is asserted in the same cycle.
  - When `p_valid && p_last`: next state is HOLD.
  - When `clear` is asserted without `p_valid`: `acc`, `count` and `sat` are all set to 0.
  - When `clear` is asserted with `p_valid`: the sum restarts from this beat, so `count` becomes 1 and `sat` takes only this add's flag.
- **HOLD:**
  - `out_valid`=1 and `in_ready`=0. `out_sum`, `out_sat` and `out_count` are held stable.
  - On `out_ready`: `acc`, `count` and `sat` are set to 0 and the state returns to ACCUM.
  - `clear` is ignored in HOLD.
- **Saturating add:**
  - A 65-bit sign-extended sum is formed.
  - Overflow occurs when both operands have the same sign and the result sign differs.
  - Positive overflow gives 0x7FFF_FFFF_FFFF_FFFF; negative overflow gives 0x8000_0000_0000_0000.
- **Empty sum:** impossible. Every sum contains at least the `in_last` beat.
- **Reset:**
  - `state`=ACCUM; `acc`, `count`, `sat`, `p_valid` and `p_last` are all 0.
  - Consequently `in_ready`=1 and `out_valid`=0 in the cycle after reset.
  - Reset mid-sum or during HOLD discards everything, with no output.

## Timing
- A beat accepted at edge T reaches `acc` at edge T+1.
- A last beat accepted at edge T gives `out_valid`=1 after edge T+1.
- Minimum latency from `in_last` handshake to `out_valid` is 2 edges.
- Throughput is one beat per cycle within a sum.
- Beats of the next sum are blocked from the edge `p_last` is captured until the cycle after the output handshake. That bubble is at least 2 cycles.
- `in_ready` and `out_valid` are combinational from registered state only. Neither depends combinationally on `in_valid` or `out_ready`.
- Producer rule: the producer holds `in_product`/`in_last` stable while `in_valid && !in_ready`. The block does not check this.

## Structure
- **Shared package `mac_pkg`:**
  - state enum `mac_state_t` {ACCUM, HOLD};
  - constants `SAT_MAX` and `SAT_MIN` (W-bit).
- **Sub-module `sat_add`** (combinational, parameter W): inputs `a` and `b`; outputs `s` and `ovf`.
- The top level holds the input register, FSM, counter and handshake logic.

## Test plan
- **Basic sum:** reset, then feed beats 100, 10000, -25000, 525 (last) back-to-back with `out_ready`=1 -> `out_sum`=-14375, `out_count`=4, `out_sat`=0. `out_valid` is high exactly one cycle, 2 edges after the last handshake.
- **Positive saturation:** 0x7FFF_FFFF_FFFF_FFF0 then 0x20 (last) -> `out_sum`=0x7FFF_FFFF_FFFF_FFFF, `out_sat`=1. A following sum of 5 (last) -> 5, `out_sat`=0, `out_count`=1.
- **Negative saturation and recovery:** 0x8000_0000_0000_0001, -2, +1000 (last) -> `out_sum`=0x8000_0000_0000_0000+1000, `out_sat`=1.
- **Backpressure:**
  - Last beat 7, with `out_ready`=0 for 5 cycles -> `out_valid` stays high and `out_sum`=7 stable.
  - `in_ready`=0 throughout while `in_valid` is held high with 9.
  - After `out_ready`: 9 is accepted only when `in_ready` returns; the next sum is 9.
- **Clear collisions:**
  - Feed 50 and 60; assert `clear` in the cycle 60 is in stage 2, then 3 (last) -> `out_sum`=63, `out_count`=2.
  - Separately: `clear` alone mid-sum, then 4 (last) -> 4, `out_count`=1.
- **Reset mid-operation:** assert `reset` during HOLD and during an active sum -> next cycle `out_valid`=0 and `in_ready`=1. The next sum of 8 (last) -> 8, `out_count`=1, `out_sat`=0.
